// File: rtl/arm7tdmi_mul_sequencer.sv
// Issue/writeback sequencer for the ARM7TDMI combinational multiplier.
// Models early-termination timing and drives results through the single RF write port.
module arm7tdmi_mul_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic        op_long,
    input  logic        op_signed,
    input  logic        op_acc,
    input  logic        op_s,
    input  logic [3:0]  rd_lo_idx,
    input  logic [3:0]  rd_hi_idx,
    input  logic [31:0] rm_val,
    input  logic [31:0] rs_val,
    input  logic [31:0] rn_hi_val,
    input  logic [31:0] rn_lo_val,
    output logic        mul_en,
    output logic [1:0]  mul_type,
    output logic        mul_signed,
    output logic        mul_long,
    output logic        mul_accumulate,
    output logic        mul_set_flags,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic [31:0] acc_hi,
    output logic [31:0] acc_lo,
    input  logic [31:0] result_hi,
    input  logic [31:0] result_lo,
    input  logic        result_ready,
    output logic        busy,
    output logic        done,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        flag_we,
    output logic        flag_n,
    output logic        flag_z
);

    typedef enum logic [1:0] {IDLE, EXEC, WB_LO, WB_HI} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_long, r_signed, r_acc, r_s;
    logic [3:0]  r_rd_lo, r_rd_hi;
    logic [31:0] r_op_a, r_op_b, r_acc_hi, r_acc_lo;
    logic [31:0] r_res_hi, r_res_lo;
    logic        r_flag_n, r_flag_z;
    logic [2:0]  r_count;
    logic [2:0]  w_cycles;
    logic        w_accept, w_capture;

    // Booth-style early termination: number of 8-bit multiplier steps Rs needs.
    function automatic logic [2:0] early_term(input logic [31:0] rs, input logic sgn_chk);
        if (rs[31:8] == '0 || (sgn_chk && (&rs[31:8])))
            return 3'd1;
        else if (rs[31:16] == '0 || (sgn_chk && (&rs[31:16])))
            return 3'd2;
        else if (rs[31:24] == '0 || (sgn_chk && (&rs[31:24])))
            return 3'd3;
        else
            return 3'd4;
    endfunction

    assign w_cycles  = early_term(rs_val, ~op_long | op_signed) + {2'b00, op_acc} + {2'b00, op_long};
    assign w_accept  = (r_state == IDLE) && start && !flush;
    assign w_capture = (r_state == EXEC) && (r_count == 3'd1) && result_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_long   <= 1'b0;
            r_signed <= 1'b0;
            r_acc    <= 1'b0;
            r_s      <= 1'b0;
            r_rd_lo  <= '0;
            r_rd_hi  <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_flag_n <= 1'b0;
            r_flag_z <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_long   <= op_long;
                r_signed <= op_signed;
                r_acc    <= op_acc;
                r_s      <= op_s;
                r_rd_lo  <= rd_lo_idx;
                r_rd_hi  <= rd_hi_idx;
                r_op_a   <= rm_val;
                r_op_b   <= rs_val;
                r_acc_hi <= rn_hi_val;
                r_acc_lo <= rn_lo_val;
                r_count  <= w_cycles;
            end else if (r_state == EXEC && r_count > 3'd1) begin
                r_count <= r_count - 3'd1;
            end
            if (w_capture) begin
                r_res_hi <= result_hi;
                r_res_lo <= result_lo;
                r_flag_n <= r_long ? result_hi[31] : result_lo[31];
                r_flag_z <= r_long ? ({result_hi, result_lo} == 64'd0) : (result_lo == 32'd0);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        mul_en         = 1'b0;
        mul_type       = 2'b00;
        mul_signed     = 1'b0;
        mul_long       = 1'b0;
        mul_accumulate = 1'b0;
        mul_set_flags  = 1'b0;
        rf_we          = 1'b0;
        rf_waddr       = '0;
        rf_wdata       = '0;
        done           = 1'b0;
        flag_we        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept)
                    w_state_nxt = EXEC;
            end
            EXEC: begin
                mul_en         = 1'b1;
                mul_type       = {r_long, r_acc};
                mul_signed     = r_signed;
                mul_long       = r_long;
                mul_accumulate = r_acc;
                mul_set_flags  = r_s;
                if (w_capture)
                    w_state_nxt = WB_LO;
            end
            WB_LO: begin
                rf_we    = 1'b1;
                rf_waddr = r_rd_lo;
                rf_wdata = r_res_lo;
                if (r_long) begin
                    w_state_nxt = WB_HI;
                end else begin
                    done        = 1'b1;
                    flag_we     = r_s;
                    w_state_nxt = IDLE;
                end
            end
            WB_HI: begin
                rf_we       = 1'b1;
                rf_waddr    = r_rd_hi;
                rf_wdata    = r_res_hi;
                done        = 1'b1;
                flag_we     = r_s;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // Abort wins over everything, including a same-cycle writeback.
        if (flush) begin
            w_state_nxt = IDLE;
            rf_we       = 1'b0;
            done        = 1'b0;
            flag_we     = 1'b0;
        end
    end

    assign busy      = (r_state != IDLE);
    assign operand_a = r_op_a;
    assign operand_b = r_op_b;
    assign acc_hi    = r_acc_hi;
    assign acc_lo    = r_acc_lo;
    assign flag_n    = r_flag_n;
    assign flag_z    = r_flag_z;

endmodule

// File: tb/tb_arm7tdmi_mul_sequencer.sv
// Randomized bench for arm7tdmi_mul_sequencer with a behavioural multiplier stub
// and an arithmetic reference model for timing, results and flags.
module tb_arm7tdmi_mul_sequencer;

    logic        clk, rst_n, start, flush;
    logic        op_long, op_signed, op_acc, op_s;
    logic [3:0]  rd_lo_idx, rd_hi_idx;
    logic [31:0] rm_val, rs_val, rn_hi_val, rn_lo_val;
    logic        mul_en, mul_signed, mul_long, mul_accumulate, mul_set_flags;
    logic [1:0]  mul_type;
    logic [31:0] operand_a, operand_b, acc_hi, acc_lo;
    logic [31:0] result_hi, result_lo;
    logic        rr;
    logic        busy, done, rf_we, flag_we, flag_n, flag_z;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_total = 0;
    int n_bad   = 0;
    int last_wb;
    logic [31:0] last_lo, last_hi;
    logic last_n, last_z;

    arm7tdmi_mul_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .op_long(op_long), .op_signed(op_signed), .op_acc(op_acc), .op_s(op_s),
        .rd_lo_idx(rd_lo_idx), .rd_hi_idx(rd_hi_idx),
        .rm_val(rm_val), .rs_val(rs_val), .rn_hi_val(rn_hi_val), .rn_lo_val(rn_lo_val),
        .mul_en(mul_en), .mul_type(mul_type), .mul_signed(mul_signed), .mul_long(mul_long),
        .mul_accumulate(mul_accumulate), .mul_set_flags(mul_set_flags),
        .operand_a(operand_a), .operand_b(operand_b), .acc_hi(acc_hi), .acc_lo(acc_lo),
        .result_hi(result_hi), .result_lo(result_lo), .result_ready(rr),
        .busy(busy), .done(done), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flag_we(flag_we), .flag_n(flag_n), .flag_z(flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational multiplier stub fed from the sequencer's outputs.
    logic [63:0] sx_a, sx_b, stub_acc, stub_prod;
    always_comb begin
        sx_a      = (mul_long && mul_signed) ? {{32{operand_a[31]}}, operand_a} : {32'd0, operand_a};
        sx_b      = (mul_long && mul_signed) ? {{32{operand_b[31]}}, operand_b} : {32'd0, operand_b};
        stub_acc  = mul_accumulate ? (mul_long ? {acc_hi, acc_lo} : {32'd0, acc_lo}) : 64'd0;
        stub_prod = sx_a * sx_b + stub_acc;
    end
    assign result_hi = stub_prod[63:32];
    assign result_lo = stub_prod[31:0];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Multiply cycles: smallest number of signed/unsigned bytes that holds Rs, plus acc and long.
    function automatic int exp_cycles(input bit lng, input bit sgn, input bit acc, input logic [31:0] rs);
        int m;
        bit chk;
        longint v, lim;
        chk = !lng || sgn;
        v = chk ? longint'($signed(rs)) : longint'({32'd0, rs});
        m = 4;
        for (int k = 3; k >= 1; k--) begin
            lim = longint'(1) << (8 * k);
            if (v < lim && v >= (chk ? -lim : 0))
                m = k;
        end
        return m + int'(acc) + int'(lng);
    endfunction

    function automatic logic [63:0] exp_result(input bit lng, input bit sgn, input bit acc,
                                               input logic [31:0] rm, input logic [31:0] rs,
                                               input logic [31:0] rnh, input logic [31:0] rnl);
        longint p;
        if (lng && sgn)
            p = longint'($signed(rm)) * longint'($signed(rs));
        else
            p = longint'({32'd0, rm}) * longint'({32'd0, rs});
        if (acc)
            p = p + (lng ? longint'({rnh, rnl}) : longint'({32'd0, rnl}));
        return lng ? 64'(p) : {32'd0, 32'(p)};
    endfunction

    task automatic do_op(input bit lng, input bit sgn, input bit acc, input bit s,
                         input logic [3:0] rlo, input logic [3:0] rhi,
                         input logic [31:0] rm, input logic [31:0] rs,
                         input logic [31:0] rnh, input logic [31:0] rnl,
                         input int stall, input int fl_at);
        int c, wl, last;
        logic [63:0] r;
        bit en, ez, hi, fin, fl;
        c    = exp_cycles(lng, sgn, acc, rs);
        r    = exp_result(lng, sgn, acc, rm, rs, rnh, rnl);
        en   = lng ? r[63] : r[31];
        ez   = lng ? (r == 64'd0) : (r[31:0] == 32'd0);
        wl   = c + stall + 1;
        last = lng ? wl + 1 : wl;
        last_wb = 0;
        @(negedge clk);
        start = 1'b1; flush = 1'b0; rr = 1'b0;
        op_long = lng; op_signed = sgn; op_acc = acc; op_s = s;
        rd_lo_idx = rlo; rd_hi_idx = rhi;
        rm_val = rm; rs_val = rs; rn_hi_val = rnh; rn_lo_val = rnl;
        #1 check_val("issue_idle", {busy, rf_we, done, mul_en}, 0);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            start = 1'(($urandom % 4) == 0);
            {op_long, op_signed, op_acc, op_s} = 4'($urandom);
            {rd_lo_idx, rd_hi_idx} = 8'($urandom);
            rm_val = $urandom; rs_val = $urandom; rn_hi_val = $urandom; rn_lo_val = $urandom;
            flush = (k == fl_at);
            rr = (k >= c + stall) ? 1'b1 : ((k < c) ? 1'($urandom % 2) : 1'b0);
            #1;
            if (k < wl) begin
                check_val("exec_ctl",
                    {busy, mul_en, mul_type, mul_signed, mul_long, mul_accumulate, mul_set_flags, rf_we, done, flag_we},
                    {1'b1, 1'b1, lng, acc, sgn, lng, acc, s, 3'b000});
                check_val("exec_opab", {operand_a, operand_b}, {rm, rs});
                check_val("exec_acc", {acc_hi, acc_lo}, {rnh, rnl});
            end else begin
                hi  = (k != wl);
                fin = hi || !lng;
                fl  = flush;
                check_val(hi ? "wbhi_ctl" : "wblo_ctl", {busy, mul_en, rf_we, done, flag_we},
                          {1'b1, 1'b0, !fl, fin && !fl, fin && s && !fl});
                if (!fl) begin
                    check_val(hi ? "wbhi_addr" : "wblo_addr", rf_waddr, hi ? rhi : rlo);
                    check_val(hi ? "wbhi_data" : "wblo_data", rf_wdata, hi ? r[63:32] : r[31:0]);
                    if (hi) last_hi = rf_wdata;
                    else begin last_lo = rf_wdata; last_wb = k; end
                end
                if (fin && s && !fl) begin
                    check_val("flags", {flag_n, flag_z}, {en, ez});
                    last_n = flag_n; last_z = flag_z;
                end
            end
            if (flush) begin
                @(negedge clk);
                start = 1'b0; flush = 1'b0;
                #1 check_val("flush_idle", {busy, rf_we, done, flag_we}, 0);
                return;
            end
        end
    endtask

    initial begin
        logic [31:0] rsr;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; rr = 1'b0;
        op_long = 0; op_signed = 0; op_acc = 0; op_s = 0;
        rd_lo_idx = 0; rd_hi_idx = 0; rm_val = 0; rs_val = 0; rn_hi_val = 0; rn_lo_val = 0;
        last_lo = 0; last_hi = 0; last_n = 0; last_z = 0; last_wb = 0;
        repeat (3) @(negedge clk);
        start = 1'b1; rm_val = 32'h1234; rs_val = 32'h55;
        #1;
        check_val("rst_ctl", {busy, done, rf_we, flag_we, flag_n, flag_z, mul_en, mul_type,
                              mul_signed, mul_long, mul_accumulate, mul_set_flags, rf_waddr}, 0);
        check_val("rst_ops", {operand_a, operand_b}, 0);
        check_val("rst_acc", {acc_hi, acc_lo}, 0);
        check_val("rst_wdata", rf_wdata, 0);
        @(negedge clk);
        start = 1'b0; rst_n = 1'b1;

        // MUL 7*5
        do_op(0, 0, 0, 0, 4'd3, 4'd9, 32'd7, 32'd5, 32'd0, 32'd0, 0, 0);
        check_val("mul_data", last_lo, 32'h00000023);
        check_val("mul_lat", last_wb, 2);
        // UMULL 0xFFFFFFFF * 0x12345678
        do_op(1, 0, 0, 0, 4'd1, 4'd2, 32'hFFFFFFFF, 32'h12345678, 32'd0, 32'd0, 0, 0);
        check_val("umull_res", {last_hi, last_lo}, 64'h12345677_EDCBA988);
        check_val("umull_lat", last_wb, 6);
        // SMULLS 2 * -256, then the same operands unsigned
        do_op(1, 1, 0, 1, 4'd5, 4'd6, 32'd2, 32'hFFFFFF00, 32'd0, 32'd0, 0, 0);
        check_val("smull_res", {last_hi, last_lo}, 64'hFFFFFFFF_FFFFFE00);
        check_val("smull_flg", {last_n, last_z}, 2'b10);
        check_val("smull_lat", last_wb, 3);
        do_op(1, 0, 0, 0, 4'd5, 4'd6, 32'd2, 32'hFFFFFF00, 32'd0, 32'd0, 0, 0);
        check_val("umull_m4_lat", last_wb, 6);
        // MULS 0 * 0x80000000
        do_op(0, 0, 0, 1, 4'd7, 4'd0, 32'd0, 32'h80000000, 32'd0, 32'd0, 0, 0);
        check_val("muls_flg", {last_n, last_z}, 2'b01);
        check_val("muls_lat", last_wb, 5);
        // UMLAL with carry into the high word and 3 stall cycles
        do_op(1, 0, 1, 0, 4'd8, 4'd9, 32'd1, 32'd1, 32'h00000001, 32'hFFFFFFFF, 3, 0);
        check_val("umlal_res", {last_hi, last_lo}, 64'h00000002_00000000);
        check_val("umlal_lat", last_wb, 7);
        // flush in the second EXEC cycle, then same-index long write
        do_op(1, 0, 0, 0, 4'd1, 4'd2, 32'hFFFFFFFF, 32'h12345678, 32'd0, 32'd0, 0, 2);
        do_op(1, 1, 1, 1, 4'd4, 4'd4, 32'h80000001, 32'h00C0FFEE, 32'h1, 32'h2, 0, 0);

        // async reset during WB_LO
        @(negedge clk);
        start = 1'b1; rr = 1'b1; op_long = 1; op_signed = 0; op_acc = 0; op_s = 1;
        rm_val = 32'd3; rs_val = 32'd4;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 check_val("pre_rst_we", rf_we, 1);
        rst_n = 1'b0;
        #1 check_val("async_rst", {busy, rf_we, done, flag_we, mul_en}, 0);
        check_val("async_rst_op", operand_a, 0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            rsr = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) rsr = ~rsr;
            do_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  4'($urandom), 4'($urandom), $urandom, rsr, $urandom, $urandom,
                  ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : 0,
                  ($urandom_range(0, 7) == 0) ? $urandom_range(1, 8) : 0);
        end

        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1 check_val("final_idle", {busy, rf_we, done}, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
